// File: rtl/axis_1553_bc_sequencer_if.sv
// rtl/axis_1553_bc_sequencer_if.sv - 16-bit word stream with 8-bit sync-type sideband
interface axis_1553_bc_sequencer_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [7:0]  tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/axis_1553_bc_sequencer.sv
// rtl/axis_1553_bc_sequencer.sv - 1553 BC message sequencer; optional mode-code handling under BC_SEQ_MODE_CODE_EN
module axis_1553_bc_sequencer #(
  parameter int clock_speed    = 20000000,
  parameter int gap_us         = 4,
  parameter int timeout_cycles = 400
) (
  input  logic                            aclk,
  input  logic                            arstn,
  input  logic                            cmd_start,
  input  logic [4:0]                      cmd_rt_addr,
  input  logic                            cmd_tr,
  input  logic [4:0]                      cmd_subaddr,
  input  logic [4:0]                      cmd_word_count,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  axis_1553_bc_sequencer_if.slave         s_axis,
  axis_1553_bc_sequencer_if.master        m_axis,
  input  logic                            en_diff
);

  localparam int GAP_CYCLES = clock_speed / 1000000 * gap_us;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W       = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

  localparam logic [7:0] SYNC_CMD  = 8'h80;
  localparam logic [7:0] SYNC_DATA = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WAIT_TX,
    S_GAP
  } state_t;

  state_t            state;
  logic              m_tvalid;
  logic [15:0]       m_tdata;
  logic [7:0]        m_tuser;
  logic [5:0]        remaining;
  logic [TO_W-1:0]   und_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tx_seen;
  logic              mode_cmd;
  logic [5:0]        start_words;
  logic              s_ready;
  logic              s_hs;
  logic              m_hs;

`ifdef BC_SEQ_MODE_CODE_EN
  assign mode_cmd = (cmd_subaddr == 5'd0) || (cmd_subaddr == 5'd31);
`else
  assign mode_cmd = 1'b0;
`endif

  // Number of BC-to-RT data words implied by the incoming descriptor
  always_comb begin
    start_words = 6'd0;
    if (mode_cmd) begin
      start_words = (!cmd_tr && cmd_word_count[4]) ? 6'd1 : 6'd0;
    end else if (!cmd_tr) begin
      start_words = (cmd_word_count == 5'd0) ? 6'd32 : {1'b0, cmd_word_count};
    end
  end

  // Upstream may only advance while words are owed and the output slot frees up this cycle
  assign s_ready = (state == S_DATA) && (remaining != 6'd0) && (!m_tvalid || m_axis.tready);
  assign s_hs    = s_axis.tvalid && s_ready;
  assign m_hs    = m_tvalid && m_axis.tready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tuser  = m_tuser;

  // Message sequencing: command word, data words, wait for the encoder, then the gap
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= 16'd0;
      m_tuser   <= 8'd0;
      remaining <= 6'd0;
      und_cnt   <= '0;
      gap_cnt   <= '0;
      tx_seen   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (busy && en_diff) begin
        tx_seen <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          // done high means the previous message closed this cycle; start waits one more cycle
          if (cmd_start && !done) begin
            busy      <= 1'b1;
            m_tvalid  <= 1'b1;
            m_tdata   <= {cmd_rt_addr, cmd_tr, cmd_subaddr, cmd_word_count};
            m_tuser   <= SYNC_CMD;
            remaining <= start_words;
            und_cnt   <= '0;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (m_axis.tready) begin
            m_tvalid <= 1'b0;
            state    <= (remaining != 6'd0) ? S_DATA : S_WAIT_TX;
          end
        end
        S_DATA: begin
          if (s_hs) begin
            m_tvalid  <= 1'b1;
            m_tdata   <= s_axis.tdata;
            m_tuser   <= SYNC_DATA;
            remaining <= remaining - 6'd1;
            und_cnt   <= '0;
          end else if (m_hs) begin
            m_tvalid <= 1'b0;
            if (remaining == 6'd0) begin
              state <= S_WAIT_TX;
            end
          end else if ((remaining != 6'd0) && !s_axis.tvalid && !m_tvalid) begin
            // Encoder is starved; give up once the source has been silent too long
            if (und_cnt == TO_W'(timeout_cycles - 1)) begin
              err       <= 1'b1;
              remaining <= 6'd0;
              und_cnt   <= '0;
              state     <= S_WAIT_TX;
            end else begin
              und_cnt <= und_cnt + TO_W'(1);
            end
          end
        end
        S_WAIT_TX: begin
          if (!m_tvalid && tx_seen && !en_diff) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            tx_seen <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_1553_bc_sequencer.sv
// tb/tb_axis_1553_bc_sequencer.sv - randomized self-checking bench for axis_1553_bc_sequencer
`timescale 1ns/1ps
module tb_axis_1553_bc_sequencer;

  localparam int CLOCK_SPEED = 20000000;
  localparam int GAP_US      = 4;
  localparam int TIMEOUT     = 400;
  localparam int GAP         = CLOCK_SPEED / 1000000 * GAP_US;
  localparam int BUDGET      = 3000;

  logic        tb_data_clk = 1'b0;
  logic        arstn;
  logic        cmd_start;
  logic [4:0]  cmd_rt_addr;
  logic        cmd_tr;
  logic [4:0]  cmd_subaddr;
  logic [4:0]  cmd_word_count;
  logic        busy;
  logic        done;
  logic        err;
  logic        en_diff;

  axis_1553_bc_sequencer_if s_axis ();
  axis_1553_bc_sequencer_if m_axis ();

  axis_1553_bc_sequencer dut (
    .aclk           (tb_data_clk),
    .arstn          (arstn),
    .cmd_start      (cmd_start),
    .cmd_rt_addr    (cmd_rt_addr),
    .cmd_tr         (cmd_tr),
    .cmd_subaddr    (cmd_subaddr),
    .cmd_word_count (cmd_word_count),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .s_axis         (s_axis),
    .m_axis         (m_axis),
    .en_diff        (en_diff)
  );

  always #25 tb_data_clk = ~tb_data_clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] preset_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data words a descriptor owes, straight from the word-count rules
  function automatic int exp_data_words(input logic tr, input logic [4:0] sa, input logic [4:0] wc);
`ifdef BC_SEQ_MODE_CODE_EN
    if (sa == 5'd0 || sa == 5'd31) return (!tr && wc[4]) ? 1 : 0;
`endif
    if (tr) return 0;
    return (wc == 5'd0) ? 32 : int'(wc);
  endfunction

  // One message: drives descriptor, upstream source, encoder sink and en_diff; checks everything observed
  task automatic run_msg(input logic [4:0] rt, input logic tr, input logic [4:0] sa, input logic [4:0] wc,
                         input int n_up_override, input int extra_up, input bit rnd_ready,
                         input bit rnd_bubble, input int stall_len, input bit ign_start, input int hold_start);
    logic [15:0] up_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] e;
    logic [23:0] prev_word;
    bit   prev_stall;
    int   n_exp, n_up, n_send, consumed, err_cnt, accept_cyc, drop_cyc, last_up_hs, delay;
    bit   exp_err, got_done, exact_timing;

    n_exp  = exp_data_words(tr, sa, wc);
    n_up   = (n_up_override >= 0) ? n_up_override : n_exp + extra_up;
    exp_err = (n_up < n_exp);
    n_send = exp_err ? n_up : n_exp;
    exact_timing = !rnd_ready && !rnd_bubble && (stall_len == 0);
    for (int i = 0; i < n_up; i++) begin
      if (preset_q.size() > 0) up_q.push_back(preset_q.pop_front());
      else up_q.push_back(16'($urandom));
    end
    exp_q.push_back({8'h80, rt, tr, sa, wc});
    for (int i = 0; i < n_send; i++) exp_q.push_back({8'h40, up_q[i]});

    consumed = 0; err_cnt = 0; accept_cyc = -1; drop_cyc = -1; last_up_hs = -1;
    delay = $urandom_range(0, 3); got_done = 0; prev_stall = 0; prev_word = '0;

    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (accept_cyc >= 0 && done) begin
        check("done_cycle", cyc, (drop_cyc >= 0) ? drop_cyc + GAP + 1 : -1);
        check("busy_falls_with_done", busy, 1'b0);
        check("err_done_excl", err, 1'b0);
        got_done = 1;
        break;
      end
      if (err) begin
        err_cnt++;
        check("err_not_with_done", done, 1'b0);
        if (exp_err && exact_timing) check("err_cycle", cyc, last_up_hs + TIMEOUT + 2);
      end
      if (prev_stall) check("stall_stable", {m_axis.tuser, m_axis.tdata}, prev_word);
      if (accept_cyc >= 0 && cyc == accept_cyc + 1) check("cmd_latency", {busy, m_axis.tvalid}, 2'b11);

      en_diff = 1'b0;
      if (accept_cyc >= 0 && cyc > accept_cyc) begin
        en_diff = (drop_cyc < 0);
        if (drop_cyc < 0 && exp_q.size() == 0 && !m_axis.tvalid && (err_cnt > 0 || !exp_err)) begin
          if (delay == 0) begin
            en_diff  = 1'b0;
            drop_cyc = cyc;
          end else begin
            delay--;
          end
        end
      end

      cmd_start = 1'b0;
      if (cyc < hold_start) begin
        cmd_start = 1'b1;
        cmd_rt_addr = rt; cmd_tr = tr; cmd_subaddr = sa; cmd_word_count = wc;
      end else if (ign_start && accept_cyc >= 0 && cyc == accept_cyc + 5) begin
        cmd_start = 1'b1;
        cmd_rt_addr = 5'($urandom); cmd_tr = 1'($urandom); cmd_subaddr = 5'($urandom); cmd_word_count = 5'($urandom);
      end
      if (cmd_start && !busy && !done && accept_cyc < 0) begin
        check("idle_before_accept", {busy, m_axis.tvalid}, 2'b00);
        accept_cyc = cyc;
      end

      if (stall_len > 0 && accept_cyc >= 0 && cyc >= accept_cyc + 3 && cyc < accept_cyc + 3 + stall_len)
        m_axis.tready = 1'b0;
      else
        m_axis.tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;

      s_axis.tvalid = (up_q.size() > 0) && (!rnd_bubble || $urandom_range(0, 2) != 0);
      s_axis.tdata  = (up_q.size() > 0) ? up_q[0] : 16'($urandom);

      #1;
      if (n_exp == 0) check("tready_stays_low", s_axis.tready, 1'b0);
      if (s_axis.tvalid && s_axis.tready) begin
        consumed++;
        void'(up_q.pop_front());
        last_up_hs = cyc;
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("word", {m_axis.tuser, m_axis.tdata}, e);
        end
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_word  = {m_axis.tuser, m_axis.tdata};
      @(negedge tb_data_clk);
    end

    check("done_seen", got_done, 1'b1);
    check("consumed", consumed, n_send);
    check("words_left", exp_q.size(), 0);
    check("err_count", err_cnt, exp_err ? 1 : 0);
    s_axis.tvalid = 1'b0;
    cmd_start = 1'b0;
    en_diff = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge tb_data_clk);
  endtask

  initial begin
    arstn = 1'b0; cmd_start = 1'b0; cmd_rt_addr = '0; cmd_tr = 1'b0; cmd_subaddr = '0; cmd_word_count = '0;
    en_diff = 1'b0; s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tuser = '0; m_axis.tready = 1'b0;
    idle(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_s_tready", s_axis.tready, 1'b0);
    check("rst_m_tvalid", m_axis.tvalid, 1'b0);
    check("rst_m_tdata", m_axis.tdata, 16'h0);
    check("rst_m_tuser", m_axis.tuser, 8'h0);
    arstn = 1'b1;
    idle(2);

    preset_q.push_back(16'hAAAA);
    preset_q.push_back(16'h5555);
    run_msg(5'd5, 1'b0, 5'd2, 5'd2, -1, 0, 0, 0, 0, 0, 1);
    idle(2);
    run_msg(5'd1, 1'b1, 5'd3, 5'd4, -1, 0, 0, 0, 0, 0, 1);
    idle(2);
    run_msg(5'd9, 1'b0, 5'd7, 5'd0, -1, 1, 0, 0, 0, 0, 1);
    idle(2);
    run_msg(5'd3, 1'b0, 5'd4, 5'd3, 1, 0, 0, 0, 0, 0, 1);
    idle(2);
    run_msg(5'd6, 1'b0, 5'd8, 5'd4, -1, 0, 0, 0, 10, 1, 1);
    run_msg(5'd7, 1'b0, 5'd9, 5'd1, -1, 0, 0, 0, 0, 0, 2);
    idle(2);
    run_msg(5'd2, 1'b0, 5'd31, 5'd17, -1, 1, 0, 0, 0, 0, 1);
    idle(2);
    run_msg(5'd2, 1'b0, 5'd31, 5'd2, -1, 1, 0, 0, 0, 0, 1);
    idle(2);

    for (int k = 0; k < 10; k++) begin
      run_msg(5'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), -1, $urandom_range(0, 2),
              1'b1, 1'b1, 0, 1'($urandom), 1);
      idle($urandom_range(1, 3));
    end

    cmd_rt_addr = 5'd4; cmd_tr = 1'b0; cmd_subaddr = 5'd5; cmd_word_count = 5'd5;
    m_axis.tready = 1'b0;
    cmd_start = 1'b1;
    idle(1);
    cmd_start = 1'b0;
    idle(3);
    check("mid_busy_before_reset", busy, 1'b1);
    #5 arstn = 1'b0;
    #1;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_tvalid", m_axis.tvalid, 1'b0);
    check("mid_reset_tdata", m_axis.tdata, 16'h0);
    check("mid_reset_tuser", m_axis.tuser, 8'h0);
    idle(1);
    arstn = 1'b1;
    idle(2);
    run_msg(5'd10, 1'b0, 5'd11, 5'd3, -1, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_1553_bc_sequencer.md
# axis_1553_bc_sequencer

Bus-controller message sequencer that sits in front of `axis_1553_encoder` and drives its AXI-Stream slave port. The block accepts a command descriptor from the register/CPU side, emits the 1553 command word with command sync, then streams the required number of BC→RT data words from an upstream AXI-Stream source with data sync. It then waits for the encoder to finish transmitting and enforces a minimum inter-message gap before accepting the next command.

## Interface

- `clock_speed`, 20000000: `aclk` frequency in Hz.
- `gap_us`, 4: minimum inter-message gap in µs. `GAP_CYCLES = clock_speed/1000000*gap_us`.
- `timeout_cycles`, 400: maximum number of consecutive cycles a data word may be missing before the message aborts.
- `aclk`, in, 1: clock.
- `arstn`, in, 1: asynchronous active-low reset.
- `cmd_start`, in, 1: descriptor strobe. Sampled only when `busy`=0.
- `cmd_rt_addr`, in, 5: remote terminal address.
- `cmd_tr`, in, 1: 1 = RT transmit (command word only); 0 = RT receive (command word plus data words).
- `cmd_subaddr`, in, 5: subaddress or mode field.
- `cmd_word_count`, in, 5: word count. 0 means 32.
- `busy`, out, 1: message in progress.
- `done`, out, 1: one-cycle pulse at the end of the gap.
- `err`, out, 1: one-cycle pulse on underrun abort.
- `s_axis_tdata`, in, 16: data words from upstream.
- `s_axis_tvalid`, in, 1: upstream valid.
- `s_axis_tready`, out, 1: upstream ready.
- `m_axis_tdata`, out, 16: data to the encoder.
- `m_axis_tvalid`, out, 1: valid to the encoder.
- `m_axis_tuser`, out, 8: sync type. `8'h80` = command/status sync; `8'h40` = data sync.
- `m_axis_tready`, in, 1: encoder ready.
- `en_diff`, in, 1: encoder transmit-active flag.

## Operation

**States:** IDLE, CMD, DATA, WAIT_TX, GAP.

- **IDLE**
  - On `cmd_start`, latch the descriptor and set `busy`.
  - Load the output register with `{rt_addr, tr, subaddr, wc}` and `tuser`=`8'h80`.
  - Set `remaining = (wc==0) ? 32 : wc`, forced to 0 when `tr`=1.
  - Go to CMD.
- **CMD**
  - Hold `m_axis_tvalid` until the `m_axis_tready` handshake.
  - After the handshake: go to DATA if `remaining`>0, else to WAIT_TX.
- **DATA**
  - `s_axis_tready = (remaining>0) && (!m_axis_tvalid || m_axis_tready)`.
  - Each upstream handshake loads the output register with `tuser`=`8'h40` and decrements `remaining`.
  - When `remaining`=0 and the final word's output handshake completes, go to WAIT_TX.
  - Underrun counter:
    - Counts cycles where `remaining`>0, `s_axis_tvalid`=0 and the output register is empty.
    - Clears on any upstream handshake.
    - On reaching `timeout_cycles`: pulse `err`, drop the remaining words without consuming them, and go to WAIT_TX. The upstream source flushes its own leftovers.
- **WAIT_TX**
  - Flag `tx_seen` is set in any busy cycle with `en_diff`=1.
  - Exit to GAP when `m_axis_tvalid`=0, `tx_seen`=1 and `en_diff`=0.
- **GAP**
  - Count `GAP_CYCLES`, then pulse `done`, clear `busy` and `tx_seen`, and return to IDLE.

**Boundary conditions:**
- `cmd_start` while `busy`=1 is ignored. No queuing.
- `cmd_start` in the same cycle that `done` pulses is ignored. The descriptor is accepted the following cycle.
- `err` and `done` never pulse in the same cycle. `done` still follows an aborted message after its gap.
- `arstn` low mid-message aborts immediately. The encoder is expected to share the same reset.

## Timing

- **Reset values:** `busy`=0, `done`=0, `err`=0, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0. State is IDLE; all counters are 0.
- **Command latency:** `m_axis_tvalid` rises on the first `aclk` edge after the `cmd_start` sample. `busy` rises on the same edge.
- **Stream handshake:** the output is a single register. Once valid, `m_axis_tdata`/`m_axis_tuser` are stable until `m_axis_tready`. Upstream-to-output latency is one cycle, with full throughput (one word per cycle when both sides are ready).
- **Gap timing:**
  - `done` asserts exactly `GAP_CYCLES`+1 cycles after the first cycle of `en_diff`=0 that satisfies the WAIT_TX exit.
  - `busy` falls on the same edge that `done` rises.

## Configuration

- **`BC_SEQ_MODE_CODE_EN` defined:** `cmd_subaddr` of 0 or 31 denotes a mode command.
  - For mode commands, data-word count is 1 when `cmd_tr`=0 and `cmd_word_count[4]`=1.
  - Otherwise the data-word count is 0 (mode code in `cmd_word_count`, no 0→32 mapping).
- **Undefined:** subaddresses 0 and 31 are treated as ordinary subaddresses with the standard word-count rule.

## Test plan

- **RT receive, 2 words:** `rt_addr`=5, `tr`=0, `sa`=2, `wc`=2, upstream `0xAAAA`, `0x5555` with the encoder always ready. Required output:
  - `m_axis` sequence `0x2842`/`8'h80`, `0xAAAA`/`8'h40`, `0x5555`/`8'h40`.
  - `done` `GAP_CYCLES`+1 cycles after `en_diff` falls.
- **RT transmit:** `rt_addr`=1, `tr`=1, `sa`=3, `wc`=4.
  - Only `0x0C64`/`8'h80` is emitted.
  - `s_axis_tready` stays 0 throughout.
- **Word count 0:** `wc`=0, `tr`=0.
  - Exactly 32 data words are consumed.
  - The 33rd upstream word is not accepted.
- **Underrun:** `wc`=3 and upstream supplies 1 word then stalls.
  - `err` pulses after `timeout_cycles` cycles.
  - `done` still follows after the gap; exactly 2 `m_axis` words were sent.
- **Back-pressure and ignored start:** hold `m_axis_tready`=0 for 10 cycles and pulse `cmd_start` while busy.
  - Data stays stable across the stall.
  - The second command is ignored; only one `done` is produced.
- **Mode code with `BC_SEQ_MODE_CODE_EN` defined:** `sa`=31, `tr`=0, `wc`=17.
  - Exactly 1 data word is sent.
  - With `wc`=2, 0 data words are sent.
